// File: rtl/ddr3_burst_reader.sv
// Issues one DDR3 read burst per trigger and checks each beat against its index.
// Tracks mismatches, passing bursts and watchdog timeouts.
module ddr3_burst_reader #(
    parameter logic [7:0]  BURSTCNT  = 8'h80,
    parameter logic [28:0] BASE_ADDR = 29'h2400000,
    parameter logic [63:0] CMP_MASK  = 64'h00000000FFFFFFFF,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        loop,
    input  logic        stop,
    input  logic        DDRAM_BUSY,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic        DDRAM_WE,
    output logic [7:0]  DDRAM_BE,
    output logic [63:0] DDRAM_DIN,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [15:0] pass_count,
    output logic [7:0]  first_err_beat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_FIN
    } state_t;

    state_t      state_q;
    logic        rd_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        timeout_q;
    logic        burst_err_q;
    logic [15:0] err_cnt_q;
    logic [15:0] pass_cnt_q;
    logic [15:0] wd_q;
    logic [15:0] wd_d;
    logic [7:0]  beat_q;
    logic [7:0]  first_q;
    logic        mismatch;

    assign wd_d     = wd_q + 16'd1;
    assign mismatch = ((DDRAM_DOUT ^ {56'b0, beat_q}) & CMP_MASK) != 64'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
            burst_err_q <= 1'b0;
            err_cnt_q   <= 16'd0;
            pass_cnt_q  <= 16'd0;
            wd_q        <= 16'd0;
            beat_q      <= 8'd0;
            first_q     <= 8'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start || (loop && !stop)) begin
                        state_q     <= S_REQ;
                        rd_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        burst_err_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!DDRAM_BUSY) begin
                        state_q <= S_DATA;
                        rd_q    <= 1'b0;
                        wd_q    <= 16'd0;
                    end
                end
                S_DATA: begin
                    if (DDRAM_DOUT_READY) begin
                        wd_q   <= 16'd0;
                        beat_q <= beat_q + 8'd1;
                        if (mismatch) begin
                            error_q     <= 1'b1;
                            burst_err_q <= 1'b1;
                            if (err_cnt_q != 16'hFFFF)
                                err_cnt_q <= err_cnt_q + 16'd1;
                            if (!error_q)
                                first_q <= beat_q;
                        end
                        if (beat_q == BURSTCNT - 8'd1) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end else if (wd_d == TIMEOUT) begin
                        // Abandon the partial burst; its mismatches stay counted.
                        wd_q      <= wd_d;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        beat_q    <= 8'd0;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    beat_q  <= 8'd0;
                    if (!burst_err_q && pass_cnt_q != 16'hFFFF)
                        pass_cnt_q <= pass_cnt_q + 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DDRAM_RD       = rd_q;
    assign DDRAM_ADDR     = BASE_ADDR;
    assign DDRAM_BURSTCNT = BURSTCNT;
    assign DDRAM_WE       = 1'b0;
    assign DDRAM_BE       = 8'hFF;
    assign DDRAM_DIN      = 64'd0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign timeout        = timeout_q;
    assign err_count      = err_cnt_q;
    assign pass_count     = pass_cnt_q;
    assign first_err_beat = first_q;

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// Directed bench for ddr3_burst_reader: table of single bursts plus
// hand-written loop, timeout and mid-burst reset sequences.
module tb_ddr3_burst_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        loop;
    logic        stop;
    logic        DDRAM_BUSY;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_WE;
    logic [7:0]  DDRAM_BE;
    logic [63:0] DDRAM_DIN;
    logic        busy;
    logic        done;
    logic        error;
    logic        timeout;
    logic [15:0] err_count;
    logic [15:0] pass_count;
    logic [7:0]  first_err_beat;

    int errors = 0;
    int checks = 0;
    int rd_acc = 0;
    int done_cnt = 0;

    ddr3_burst_reader #(
        .TIMEOUT(16'd16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .loop(loop),
        .stop(stop),
        .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(DDRAM_RD),
        .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_WE(DDRAM_WE),
        .DDRAM_BE(DDRAM_BE),
        .DDRAM_DIN(DDRAM_DIN),
        .busy(busy),
        .done(done),
        .error(error),
        .timeout(timeout),
        .err_count(err_count),
        .pass_count(pass_count),
        .first_err_beat(first_err_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (DDRAM_RD && !DDRAM_BUSY)
            rd_acc <= rd_acc + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory model: wait for RD, hold BUSY for busy_cyc cycles,
    // then return nbeats beats with optional corruption and stop request.
    task automatic serve(input int busy_cyc, input logic [7:0] c1,
                         input logic [7:0] c2, input int nbeats,
                         input int stop_beat);
        logic [7:0] lo;
        DDRAM_BUSY = (busy_cyc > 0);
        for (int w = 0; w < 50 && !DDRAM_RD; w++)
            @(negedge clk);
        if (!DDRAM_RD) begin
            errors++;
            checks++;
            $display("FAIL rd_wait: got RD=0 want RD=1 within 50 cycles");
        end
        for (int k = 0; k < busy_cyc; k++) begin
            chk("hold_rd", DDRAM_RD, 1);
            chk("hold_addr", DDRAM_ADDR, 29'h2400000);
            chk("hold_bcnt", DDRAM_BURSTCNT, 8'h80);
            @(negedge clk);
        end
        DDRAM_BUSY = 1'b0;
        @(negedge clk);
        for (int i = 0; i < nbeats; i++) begin
            lo = i[7:0];
            if (lo == c1 || lo == c2)
                lo = lo ^ 8'h01;
            if (i == stop_beat)
                stop = 1'b1;
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = {$urandom(), 24'd0, lo};
            @(negedge clk);
        end
        DDRAM_DOUT_READY = 1'b0;
        DDRAM_DOUT = 64'd0;
    endtask

    typedef struct {
        int          busy_cyc;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [15:0] e_err;
        logic [15:0] e_pass;
        logic [7:0]  e_first;
        logic        e_error;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int rd0;
        int dn0;

        tbl[0] = '{0, 8'hFF, 8'hFF, 16'd0, 16'd1, 8'd0,   1'b0};
        tbl[1] = '{5, 8'hFF, 8'hFF, 16'd0, 16'd1, 8'd0,   1'b0};
        tbl[2] = '{0, 8'd3,  8'd100, 16'd2, 16'd0, 8'd3,  1'b1};
        tbl[3] = '{2, 8'd0,  8'd127, 16'd2, 16'd0, 8'd0,  1'b1};
        tbl[4] = '{1, 8'd127, 8'hFF, 16'd1, 16'd0, 8'd127, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        loop = 1'b0;
        stop = 1'b0;
        DDRAM_BUSY = 1'b0;
        DDRAM_DOUT = 64'd0;
        DDRAM_DOUT_READY = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_rd", DDRAM_RD, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_pass_count", pass_count, 0);
        chk("rst_first", first_err_beat, 0);
        chk("tie_we", DDRAM_WE, 0);
        chk("tie_be", DDRAM_BE, 8'hFF);
        chk("tie_din", DDRAM_DIN, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            rd0 = rd_acc;
            dn0 = done_cnt;
            @(negedge clk);
            start = 1'b1;
            DDRAM_BUSY = (tbl[v].busy_cyc > 0);
            @(negedge clk);
            start = 1'b0;
            chk("req_addr", DDRAM_ADDR, 29'h2400000);
            chk("req_bcnt", DDRAM_BURSTCNT, 8'h80);
            serve(tbl[v].busy_cyc, tbl[v].c1, tbl[v].c2, 128, -1);
            chk("fin_done", done, 1);
            repeat (4) @(negedge clk);
            chk("vec_err_count", err_count, tbl[v].e_err);
            chk("vec_pass_count", pass_count, tbl[v].e_pass);
            chk("vec_first", first_err_beat, tbl[v].e_first);
            chk("vec_error", error, tbl[v].e_error);
            chk("vec_timeout", timeout, 0);
            chk("vec_busy", busy, 0);
            chk("vec_rd_acc", rd_acc - rd0, 1);
            chk("vec_done_cnt", done_cnt - dn0, 1);
        end

        // start and stop together in IDLE still launch a burst
        do_reset();
        rd0 = rd_acc;
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", busy, 1);
        serve(0, 8'hFF, 8'hFF, 128, -1);
        repeat (4) @(negedge clk);
        chk("startstop_pass", pass_count, 1);
        chk("startstop_rd", rd_acc - rd0, 1);

        // loop mode: three bursts, stop raised inside the third
        do_reset();
        rd0 = rd_acc;
        dn0 = done_cnt;
        @(negedge clk);
        loop = 1'b1;
        serve(0, 8'hFF, 8'hFF, 128, -1);
        serve(0, 8'hFF, 8'hFF, 128, -1);
        serve(0, 8'hFF, 8'hFF, 128, 60);
        repeat (20) @(negedge clk);
        chk("loop_rd", rd_acc - rd0, 3);
        chk("loop_done", done_cnt - dn0, 3);
        chk("loop_pass", pass_count, 3);
        chk("loop_busy", busy, 0);
        chk("loop_rd_low", DDRAM_RD, 0);
        loop = 1'b0;
        stop = 1'b0;

        // watchdog: only 10 of 128 beats arrive
        do_reset();
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve(0, 8'hFF, 8'hFF, 10, -1);
        repeat (15) @(negedge clk);
        chk("to_busy_before", busy, 1);
        chk("to_flag_before", timeout, 0);
        @(negedge clk);
        chk("to_busy_after", busy, 0);
        chk("to_flag_after", timeout, 1);
        repeat (3) @(negedge clk);
        chk("to_done", done_cnt - dn0, 0);
        chk("to_pass", pass_count, 0);

        // reset mid-burst, then stray beats
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve(0, 8'd10, 8'hFF, 50, -1);
        chk("mid_err_pre", err_count, 1);
        reset = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_rd", DDRAM_RD, 0);
        chk("mid_error", error, 0);
        chk("mid_err_count", err_count, 0);
        chk("mid_first", first_err_beat, 0);
        @(negedge clk);
        reset = 1'b0;
        rd0 = rd_acc;
        dn0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = 64'hDEAD_BEEF_0000_00AA;
            @(negedge clk);
        end
        DDRAM_DOUT_READY = 1'b0;
        @(negedge clk);
        chk("stray_err_count", err_count, 0);
        chk("stray_pass_count", pass_count, 0);
        chk("stray_error", error, 0);
        chk("stray_busy", busy, 0);
        chk("stray_timeout", timeout, 0);
        chk("stray_rd", rd_acc - rd0, 0);
        chk("stray_done", done_cnt - dn0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
